// File: rtl/mole_pkg.sv
// Shared types and constants for the mole spawner: mole count, FSM state
// encoding and the per-level window table in half-second units.
package mole_pkg;

    localparam int NUM_MOLES = 18;
    localparam int IDX_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RUNNING = 2'd2,
        ST_EXPIRED = 2'd3
    } mole_state_e;

    // Window length per difficulty level, in half-seconds (level 0 is slowest).
    localparam int unsigned HALF_SEC_MULT [4] = '{4, 3, 2, 1};

    function automatic int unsigned window_cycles(input logic [1:0] level,
                                                  input int unsigned clk_freq_hz);
        return (HALF_SEC_MULT[level] * clk_freq_hz) / 2;
    endfunction

    function automatic logic [NUM_MOLES-1:0] mole_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_MOLES-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_MOLES; i++) begin
            v[i] = (idx == IDX_W'(i));
        end
        return v;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11 (maximal length); a non-zero seed
// keeps it out of the all-zero lock-up state forever.
module mole_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (enable) begin
            state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
        end
    end

endmodule

// File: rtl/mole_spawner.sv
// Picks a pseudo-random mole, lights its LED and times the hit window.
// Optional macro MOLE_NO_REPEAT_EN: never spawn the same mole twice in a row.
module mole_spawner
    import mole_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ready_for_mole,
    input  logic                 timeout_start,
    input  logic [1:0]           level_number,
    output logic [NUM_MOLES-1:0] led_number,
    output logic                 timeout,
    output mole_state_e          state
);

    localparam int CNT_W = $clog2(2 * CLK_FREQ_HZ);

    localparam logic [CNT_W-1:0] WIN_M1 [4] = '{
        CNT_W'(window_cycles(2'd0, CLK_FREQ_HZ) - 1),
        CNT_W'(window_cycles(2'd1, CLK_FREQ_HZ) - 1),
        CNT_W'(window_cycles(2'd2, CLK_FREQ_HZ) - 1),
        CNT_W'(window_cycles(2'd3, CLK_FREQ_HZ) - 1)
    };

    logic [CNT_W-1:0] count;
    logic [15:0]      lfsr;
    logic [IDX_W-1:0] raw_idx;
    logic [IDX_W-1:0] cand_idx;
    logic [IDX_W-1:0] pick_idx;
    logic             unused_lfsr_hi;

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (1'b1),
        .state  (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:IDX_W];

    // Fold 18..31 back onto 0..13 so every value maps to a real mole.
    always_comb begin
        raw_idx  = lfsr[IDX_W-1:0];
        cand_idx = (raw_idx >= IDX_W'(NUM_MOLES)) ? raw_idx - IDX_W'(NUM_MOLES) : raw_idx;
    end

`ifdef MOLE_NO_REPEAT_EN
    logic [IDX_W-1:0] prev_idx;

    always_comb begin
        pick_idx = cand_idx;
        if (cand_idx == prev_idx) begin
            pick_idx = (cand_idx == IDX_W'(NUM_MOLES - 1)) ? '0 : cand_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_idx <= '0;
        end else if (ready_for_mole) begin
            prev_idx <= pick_idx;
        end
    end
`else
    assign pick_idx = cand_idx;
`endif

    // ready_for_mole is a one-cycle request that wins over any countdown or
    // expiry in the same cycle; timeout_start is a level that clocks the window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            led_number <= '0;
            timeout    <= 1'b0;
            count      <= '0;
        end else if (ready_for_mole) begin
            state      <= ST_ARMED;
            led_number <= mole_onehot(pick_idx);
            timeout    <= 1'b1;
            count      <= WIN_M1[level_number];
        end else begin
            case (state)
                ST_ARMED, ST_RUNNING: begin
                    if (timeout_start) begin
                        if (count != '0) begin
                            count <= count - 1'b1;
                            state <= ST_RUNNING;
                        end else begin
                            state      <= ST_EXPIRED;
                            led_number <= '0;
                            timeout    <= 1'b0;
                        end
                    end else if (state == ST_RUNNING) begin
                        state      <= ST_IDLE;
                        led_number <= '0;
                        timeout    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_spawner.sv
// Bench for mole_spawner at CLK_FREQ_HZ=8: directed window/priority/reset cases
// followed by randomized spawns, checked against a cycle-level reference model.
module tb_mole_spawner;
    import mole_pkg::*;

    localparam int unsigned CLK_HZ = 8;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready_for_mole;
    logic        timeout_start;
    logic [1:0]  level_number;
    logic [17:0] led_number;
    logic        timeout;
    mole_state_e state;

    always #5 clk = ~clk;

    mole_spawner #(
        .CLK_FREQ_HZ (CLK_HZ),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ready_for_mole (ready_for_mole),
        .timeout_start  (timeout_start),
        .level_number   (level_number),
        .led_number     (led_number),
        .timeout        (timeout),
        .state          (state)
    );

    int compared   = 0;
    int mismatched = 0;

    // entry: {reset_edge, spawn, led[17:0], timeout, state[1:0]}
    logic [22:0] exp_q[$];
    bit          checking = 1'b0;

    // reference model: window expressed as timeout_start cycles still allowed
    logic [15:0] m_lfsr;
    logic [17:0] m_led;
    logic        m_to;
    mole_state_e m_st;
    int          m_rem;
    int          m_prev;

    bit          seen[18];
    int          last_idx = -1;
    int          got_idx;
    logic [22:0] e;

    function automatic int win_len(input logic [1:0] lvl);
        case (lvl)
            2'd0:    return 2 * CLK_HZ;
            2'd1:    return 3 * CLK_HZ / 2;
            2'd2:    return CLK_HZ;
            default: return CLK_HZ / 2;
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic rdy, input logic ts, input logic [1:0] lvl);
        logic rst_bit;
        logic spawn_bit;
        int   idx;
        rst_bit   = 1'b0;
        spawn_bit = 1'b0;
        if (!r) begin
            m_lfsr  = SEED;
            m_led   = '0;
            m_to    = 1'b0;
            m_st    = ST_IDLE;
            m_rem   = 0;
            m_prev  = 0;
            rst_bit = 1'b1;
        end else begin
            if (rdy) begin
                idx = int'(m_lfsr) % 32;
                if (idx >= 18) idx = idx - 18;
`ifdef MOLE_NO_REPEAT_EN
                if (idx == m_prev) idx = (idx + 1) % 18;
`endif
                m_prev    = idx;
                m_led     = '0;
                m_led[idx] = 1'b1;
                m_rem     = win_len(lvl);
                m_to      = 1'b1;
                m_st      = ST_ARMED;
                spawn_bit = 1'b1;
            end else if (m_st == ST_ARMED || m_st == ST_RUNNING) begin
                if (ts) begin
                    if (m_rem == 1) begin
                        m_st  = ST_EXPIRED;
                        m_led = '0;
                        m_to  = 1'b0;
                    end else begin
                        m_rem = m_rem - 1;
                        m_st  = ST_RUNNING;
                    end
                end else if (m_st == ST_RUNNING) begin
                    m_st  = ST_IDLE;
                    m_led = '0;
                    m_to  = 1'b0;
                end
            end
            m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
        end
        exp_q.push_back({rst_bit, spawn_bit, m_led, m_to, m_st});
    endtask

    task automatic drive(input logic r, input logic rdy, input logic ts, input logic [1:0] lvl);
        @(negedge clk);
        rst_n          = r;
        ready_for_mole = rdy;
        timeout_start  = ts;
        level_number   = lvl;
        model_edge(r, rdy, ts, lvl);
        checking = 1'b1;
    endtask

    // monitor: one expected entry per clock edge
    always @(posedge clk) begin
        if (checking) begin
            #1;
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL queue_empty t=%0t: DUT produced a cycle with no expected entry", $time);
            end else begin
                e = exp_q.pop_front();
                if ({led_number, timeout, state} !== e[20:0]) begin
                    mismatched++;
                    $display("FAIL cycle_out t=%0t got led=%h to=%b st=%0d, expected led=%h to=%b st=%0d",
                             $time, led_number, timeout, state, e[20:3], e[2], e[1:0]);
                end
                if (e[22]) last_idx = -1;
                if (e[21]) begin
                    compared++;
                    if ($countones(led_number) != 1) begin
                        mismatched++;
                        $display("FAIL onehot t=%0t got led=%h, expected exactly one bit set", $time, led_number);
                    end else begin
                        got_idx = 0;
                        for (int i = 0; i < 18; i++) if (led_number[i]) got_idx = i;
                        seen[got_idx] = 1'b1;
`ifdef MOLE_NO_REPEAT_EN
                        compared++;
                        if (got_idx == last_idx) begin
                            mismatched++;
                            $display("FAIL no_repeat t=%0t got index %0d twice, expected a different index", $time, got_idx);
                        end
`endif
                        last_idx = got_idx;
                    end
                end
            end
        end
    end

    initial begin
        int n_seen;
        // reset with a coincident ready_for_mole, which must be ignored
        drive(1'b0, 1'b1, 1'b0, 2'd0);
        drive(1'b0, 1'b1, 1'b1, 2'd3);
        drive(1'b1, 1'b0, 1'b0, 2'd0);

        // level 3: four-cycle window, then expiry; further timeout_start ignored
        drive(1'b1, 1'b1, 1'b0, 2'd3);
        repeat (6) drive(1'b1, 1'b0, 1'b1, 2'd3);

        // level 0: hit after five cycles goes idle without expiry
        drive(1'b1, 1'b1, 1'b0, 2'd0);
        repeat (5) drive(1'b1, 1'b0, 1'b1, 2'd0);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 2'd0);

        // new request exactly when the counter hits zero reloads a full window
        drive(1'b1, 1'b1, 1'b0, 2'd3);
        repeat (3) drive(1'b1, 1'b0, 1'b1, 2'd3);
        drive(1'b1, 1'b1, 1'b1, 2'd2);
        repeat (10) drive(1'b1, 1'b0, 1'b1, 2'd2);

        // armed and waiting holds the window, then the full 12 cycles run
        drive(1'b1, 1'b1, 1'b0, 2'd1);
        repeat (10) drive(1'b1, 1'b0, 1'b0, 2'd1);
        repeat (14) drive(1'b1, 1'b0, 1'b1, 2'd1);

        // reset mid-window, then the same spawn pattern restarts from the seed
        for (int pass = 0; pass < 2; pass++) begin
            drive(1'b1, 1'b1, 1'b0, 2'd2);
            repeat (3) drive(1'b1, 1'b0, 1'b1, 2'd2);
            drive(1'b0, 1'b0, 1'b1, 2'd2);
            for (int k = 0; k < 20; k++) begin
                drive(1'b1, 1'b1, 1'b0, 2'(k));
                drive(1'b1, 1'b0, 1'b1, 2'(k));
            end
        end

        // 1000 spawns with random levels and random gaps
        for (int k = 0; k < 1000; k++) begin
            drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3))
                drive(1'b1, 1'b0, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
        end

        // free-running random traffic including occasional resets
        for (int k = 0; k < 2000; k++) begin
            drive(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)));
        end

        @(posedge clk);
        #2;
        checking = 1'b0;

        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL queue_drain got %0d entries left, expected 0", exp_q.size());
        end

        n_seen = 0;
        for (int i = 0; i < 18; i++) if (seen[i]) n_seen++;
        compared++;
        if (n_seen != 18) begin
            mismatched++;
            $display("FAIL coverage got %0d distinct mole indices, expected 18", n_seen);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mole_spawner.md
MOLE_SPAWNER -- requirements
Module: mole_spawner

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50_000_000, clk frequency used to size mole windows.
REQ-002 Parameter LFSR_SEED, 16 bits, default 16'hACE1, non-zero LFSR reset value.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 ready_for_mole  input  1  game FSM requests a new mole (one-cycle pulse).
REQ-006 timeout_start  input  1  game FSM is waiting for a hit; the window counts down while high.
REQ-007 level_number  input  2  difficulty level 0..3.
REQ-008 led_number  output  18  one-hot active mole; all-zero when no mole is active.
REQ-009 timeout  output  1  1 = time remaining, 0 = window expired or idle.

Function
REQ-010 States SHALL be IDLE, ARMED, RUNNING and EXPIRED; all outputs SHALL be registered.
REQ-011 WINDOW(level) SHALL be 0: 2*CLK_FREQ_HZ, 1: 3*CLK_FREQ_HZ/2, 2: CLK_FREQ_HZ, 3: CLK_FREQ_HZ/2 cycles.
REQ-012 level_number SHALL be sampled only in the ready_for_mole cycle.
REQ-013 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle outside reset and SHALL never reach zero.
REQ-014 Candidate index = lfsr[4:0]; if the index is >= 18, 18 SHALL be subtracted, giving 0..17.
REQ-015 ready_for_mole=1 in any state: next cycle the block SHALL enter ARMED, set led_number to the one-hot candidate, load the counter with WINDOW-1, and set timeout=1. Output latency is exactly 1 cycle.
REQ-016 ARMED or RUNNING with timeout_start=1: a counter > 0 SHALL decrement and the state SHALL be RUNNING.
REQ-017 Counter == 0 with timeout_start=1: next state SHALL be EXPIRED, with timeout=0 and led_number=0. timeout is therefore high for exactly WINDOW timeout_start cycles.
REQ-018 ARMED with timeout_start=0: the block SHALL hold state and counter.
REQ-019 RUNNING with timeout_start=0 (hit or game reset): next state SHALL be IDLE, with led_number=0 and timeout=0.
REQ-020 In EXPIRED and IDLE the block SHALL hold until ready_for_mole.
REQ-021 ready_for_mole SHALL take priority over countdown and expiry in the same cycle; ready_for_mole arriving while counter == 0 reloads, and timeout SHALL NOT drop.
REQ-022 The counter SHALL be ceil(log2(2*CLK_FREQ_HZ)) bits wide and SHALL never underflow.

Reset
REQ-023 rst_n=0 at a clock edge: state=IDLE, led_number=0, timeout=0, counter=0, lfsr=LFSR_SEED, previous index=0. This applies in every state, including mid-window.
REQ-024 ready_for_mole SHALL be ignored in the reset cycle.

Configuration
REQ-025 Macro MOLE_NO_REPEAT_EN defined: if the candidate equals the previous index, the block SHALL use (candidate+1) mod 18. Consecutive moles never repeat.
REQ-026 Macro MOLE_NO_REPEAT_EN undefined: the candidate SHALL be used unmodified, and the previous-index register SHALL be omitted.

Structure
REQ-027 Package mole_pkg SHALL hold NUM_MOLES=18, the state enum, and the level window multiplier table (in half-seconds: 4,3,2,1).
REQ-028 Sub-module mole_lfsr (seed parameter, enable, 16-bit state output) SHALL be instantiated once.

Verification (CLK_FREQ_HZ=8, so windows are 16/12/8/4 cycles)
REQ-029 level 3, ready_for_mole pulse, then timeout_start held high -> led_number one-hot the next cycle; timeout high for exactly 4 cycles, then 0 with led_number=0.
REQ-030 level 0, timeout_start dropped after 5 cycles -> IDLE next cycle, timeout=0, led_number=0, no expiry.
REQ-031 ready_for_mole coincident with counter == 0 -> timeout stays 1, new mole loaded, counter = WINDOW-1.
REQ-032 rst_n=0 for 1 cycle mid-RUNNING -> outputs 0 next cycle; after release, the mole sequence repeats identically from seed 16'hACE1.
REQ-033 1000 consecutive spawns -> led_number always exactly one-hot, every index 0..17 seen. With MOLE_NO_REPEAT_EN, no two consecutive indices are equal.
REQ-034 ARMED with timeout_start=0 for 10 cycles -> counter unchanged, timeout=1 throughout.
